// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus synchroniser.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_IDX_PTR,
        ST_WRITE,
        ST_READ
    } state_t;

    // Bit-counter value at which the capture edge is the ACK slot
    localparam logic [3:0] BIT_ACK = 4'd8;

    // Number of synchroniser flops on each pad input
    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchroniser and START/STOP/capture/update detector for an I2C bus.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic start_det,
    output logic stop_det,
    output logic capture,
    output logic update
);

    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic                  scl_s;
    logic                  scl_d;
    logic                  sda_d;

    // Synchronise both pads and keep one history sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], scl};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], sda};
            scl_d    <= scl_sync[SYNC_DEPTH-1];
            sda_d    <= sda_sync[SYNC_DEPTH-1];
        end
    end

    assign scl_s = scl_sync[SYNC_DEPTH-1];
    assign sda_s = sda_sync[SYNC_DEPTH-1];

    // Decode bus conditions from current and previous synchronised samples
    always_comb begin
        start_det = scl_s & scl_d & sda_d & ~sda_s;
        stop_det  = scl_s & scl_d & ~sda_d & sda_s;
        capture   = scl_s & ~scl_d;
        update    = ~scl_s & scl_d;
    end

endmodule

// File: rtl/i2c_csr_target.sv
// I2C target bridging an external host onto the internal 8-bit CSR bus.
module i2c_csr_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR  = 7'h4a,
    parameter logic [6:0]  ADDR_MASK = 7'h7f,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned DEPTH     = 32,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic             sda_out,
    output logic [6:0]       dev_sel,
    output logic [IDX_W-1:0] csr_a,
    input  logic [7:0]       csr_di,
    output logic             csr_re,
    output logic             csr_we,
    output logic [7:0]       csr_do,
    output logic             bus_active
);

    logic             sda_s;
    logic             start_det;
    logic             stop_det;
    logic             capture;
    logic             update;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift_in;
    logic [7:0]       shift_out;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;
    logic             load_pend;
    logic             addr_match;
    logic             idx_valid;
    logic             ack_slot;
    logic             need_ack;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det),
        .capture   (capture),
        .update    (update)
    );

    // Protocol state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and byte-level decisions
    always_comb begin
        state_d    = state_q;
        addr_match = (shift_in[7:1] & ADDR_MASK) == (I2C_ADDR & ADDR_MASK);
        // A byte below DEPTH necessarily has no bits set above IDX_W
        idx_valid  = 32'(shift_in) < DEPTH;
        ack_slot   = capture && (bit_cnt == BIT_ACK);
        need_ack   = (bit_cnt == BIT_ACK) &&
                     (((state_q == ST_DEV_ADDR) && addr_match) ||
                      ((state_q == ST_IDX_PTR) && idx_valid) ||
                      (state_q == ST_WRITE));
        if (!AUTO_INC)                         ptr_next = ptr;
        else if (ptr == IDX_W'(DEPTH - 1))     ptr_next = '0;
        else                                   ptr_next = ptr + IDX_W'(1);

        if (start_det) begin
            state_d = ST_DEV_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else if (ack_slot) begin
            case (state_q)
                ST_DEV_ADDR: begin
                    if (!addr_match)      state_d = ST_IDLE;
                    else if (shift_in[0]) state_d = ST_READ;
                    else                  state_d = ST_IDX_PTR;
                end
                ST_IDX_PTR: state_d = idx_valid ? ST_WRITE : ST_IDLE;
                ST_READ:    if (sda_s) state_d = ST_IDLE;
                default:    ;
            endcase
        end
    end

    // Bit/byte datapath, CSR strobes, index pointer and SDA drive
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_in   <= '0;
            shift_out  <= '0;
            ptr        <= '0;
            load_pend  <= 1'b0;
            sda_out    <= 1'b1;
            dev_sel    <= '0;
            csr_we     <= 1'b0;
            csr_do     <= '0;
            bus_active <= 1'b0;
        end else begin
            csr_we    <= 1'b0;
            load_pend <= 1'b0;
            if (start_det) begin
                bus_active <= 1'b1;
                bit_cnt    <= '0;
                sda_out    <= 1'b1;
            end else if (stop_det) begin
                bus_active <= 1'b0;
                sda_out    <= 1'b1;
            end else begin
                if (capture) begin
                    shift_in <= {shift_in[6:0], sda_s};
                    bit_cnt  <= (bit_cnt == BIT_ACK) ? '0 : bit_cnt + 4'd1;
                end
                // Write pointer advances after the strobe so csr_a holds during csr_we
                if (csr_we) ptr <= ptr_next;
                if (ack_slot) begin
                    case (state_q)
                        ST_DEV_ADDR: begin
                            if (addr_match) begin
                                dev_sel <= shift_in[7:1];
                                if (shift_in[0]) load_pend <= 1'b1;
                            end
                        end
                        ST_IDX_PTR: if (idx_valid) ptr <= shift_in[IDX_W-1:0];
                        ST_WRITE: begin
                            csr_we <= 1'b1;
                            csr_do <= shift_in;
                        end
                        ST_READ: begin
                            ptr <= ptr_next;
                            if (!sda_s) load_pend <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (load_pend) shift_out <= csr_di;
                if (update) begin
                    if (state_q == ST_IDLE) begin
                        sda_out <= 1'b1;
                    end else if (need_ack) begin
                        sda_out <= 1'b0;
                    end else if ((state_q == ST_READ) && (bit_cnt != BIT_ACK)) begin
                        sda_out   <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                    end else begin
                        sda_out <= 1'b1;
                    end
                end
                if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) sda_out <= 1'b1;
            end
        end
    end

    assign csr_a  = ptr;
    assign csr_re = load_pend;

endmodule

// File: tb/tb_i2c_csr_target.sv
// Directed self-checking bench for i2c_csr_target (default and variant builds).
`timescale 1ns/1ps
module tb_i2c_csr_target;
    import i2c_pkg::*;

    localparam int Q = 50;  // quarter SCL period in ns (SCL = 5 MHz, clk = 100 MHz)

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sel = 1'b0;

    logic       scl0, sda0, scl1, sda1, sda_line;
    logic       sda_out0, sda_out1;
    logic [6:0] dev_sel0, dev_sel1;
    logic [4:0] csr_a0, csr_a1;
    logic [7:0] csr_di0, csr_di1, csr_do0, csr_do1;
    logic       csr_re0, csr_re1, csr_we0, csr_we1;
    logic       bus_active0, bus_active1;

    int errors = 0;
    int checks = 0;

    logic [4:0] we0_idx[$];
    logic [7:0] we0_dat[$];
    logic [4:0] re0_idx[$];
    logic [4:0] we1_idx[$];
    logic [7:0] we1_dat[$];
    int         re1_n = 0;
    logic       drv1 = 1'b0;

    always #5 clk = ~clk;

    assign scl0     = sel ? 1'b1 : scl_m;
    assign sda0     = sel ? 1'b1 : (sda_m & sda_out0);
    assign scl1     = sel ? scl_m : 1'b1;
    assign sda1     = sel ? (sda_m & sda_out1) : 1'b1;
    assign sda_line = sel ? sda1 : sda0;
    assign csr_di0  = {3'b101, csr_a0};
    assign csr_di1  = {3'b110, csr_a1};

    i2c_csr_target dut0 (
        .clk(clk), .rst(rst), .scl(scl0), .sda(sda0), .sda_out(sda_out0),
        .dev_sel(dev_sel0), .csr_a(csr_a0), .csr_di(csr_di0), .csr_re(csr_re0),
        .csr_we(csr_we0), .csr_do(csr_do0), .bus_active(bus_active0)
    );

    i2c_csr_target #(
        .I2C_ADDR(7'h4a), .ADDR_MASK(7'h7c), .IDX_W(5), .DEPTH(20), .AUTO_INC(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .scl(scl1), .sda(sda1), .sda_out(sda_out1),
        .dev_sel(dev_sel1), .csr_a(csr_a1), .csr_di(csr_di1), .csr_re(csr_re1),
        .csr_we(csr_we1), .csr_do(csr_do1), .bus_active(bus_active1)
    );

    always @(negedge clk) begin
        if (csr_we0) begin we0_idx.push_back(csr_a0); we0_dat.push_back(csr_do0); end
        if (csr_re0) re0_idx.push_back(csr_a0);
        if (csr_we1) begin we1_idx.push_back(csr_a1); we1_dat.push_back(csr_do1); end
        if (csr_re1) re1_n++;
        if (!sda_out1) drv1 = 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(4*Q);
    endtask

    task automatic i2c_bit(input logic b, output logic seen);
        sda_m = b; #(Q);
        scl_m = 1'b1; #(Q);
        seen = sda_line; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic i2c_wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic i2c_rd_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(~ack, s);
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        if (sda_out0 !== 1'b1) begin $display("FAIL rst_sda_out: got %b want 1", sda_out0); errors++; end
        checks++;
        if (csr_a0 !== 5'd0) begin $display("FAIL rst_csr_a: got %h want 00", csr_a0); errors++; end
        checks++;
        if (csr_do0 !== 8'd0) begin $display("FAIL rst_csr_do: got %h want 00", csr_do0); errors++; end
        checks++;
        if (dev_sel0 !== 7'd0) begin $display("FAIL rst_dev_sel: got %h want 00", dev_sel0); errors++; end
        checks++;
        if ({csr_we0, csr_re0, bus_active0} !== 3'b000) begin
            $display("FAIL rst_strobes: got %b want 000", {csr_we0, csr_re0, bus_active0}); errors++;
        end
        checks++;
        if (dut0.state_q !== ST_IDLE) begin $display("FAIL rst_state: got %0d want IDLE", dut0.state_q); errors++; end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        sel = 1'b0;
        we0_idx.delete(); we0_dat.delete(); re0_idx.delete();
        i2c_start();
        i2c_wr_byte(8'h94, a0);
        i2c_wr_byte(8'h03, a1);
        if (bus_active0 !== 1'b1) begin $display("FAIL wr_bus_active: got %b want 1", bus_active0); errors++; end
        checks++;
        i2c_wr_byte(8'hA5, a2);
        i2c_wr_byte(8'h5A, a3);
        i2c_stop();
        if ({a0, a1, a2, a3} !== 4'b1111) begin $display("FAIL wr_acks: got %b want 1111", {a0, a1, a2, a3}); errors++; end
        checks++;
        if (bus_active0 !== 1'b0) begin $display("FAIL wr_bus_idle: got %b want 0", bus_active0); errors++; end
        checks++;
        if (we0_idx.size() != 2) begin
            $display("FAIL wr_count: got %0d want 2", we0_idx.size()); errors++;
        end else begin
            if (we0_idx[0] !== 5'h03 || we0_dat[0] !== 8'hA5) begin
                $display("FAIL wr_first: got idx %h data %h want idx 03 data a5", we0_idx[0], we0_dat[0]); errors++;
            end
            checks++;
            if (we0_idx[1] !== 5'h04 || we0_dat[1] !== 8'h5A) begin
                $display("FAIL wr_second: got idx %h data %h want idx 04 data 5a", we0_idx[1], we0_dat[1]); errors++;
            end
            checks++;
        end
        checks++;
        if (re0_idx.size() != 0) begin $display("FAIL wr_no_re: got %0d want 0", re0_idx.size()); errors++; end
        checks++;
        if (csr_a0 !== 5'h05) begin $display("FAIL wr_ptr: got %h want 05", csr_a0); errors++; end
        checks++;
    endtask

    task automatic test_read_wrap();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        sel = 1'b0;
        we0_idx.delete(); we0_dat.delete(); re0_idx.delete();
        i2c_start();
        i2c_wr_byte(8'h94, a0);
        i2c_wr_byte(8'h1F, a1);
        i2c_rstart();
        i2c_wr_byte(8'h95, a2);
        i2c_rd_byte(1'b1, d0);
        i2c_rd_byte(1'b0, d1);
        i2c_stop();
        if ({a0, a1, a2} !== 3'b111) begin $display("FAIL rd_acks: got %b want 111", {a0, a1, a2}); errors++; end
        checks++;
        if (d0 !== 8'hBF) begin $display("FAIL rd_byte0: got %h want bf", d0); errors++; end
        checks++;
        if (d1 !== 8'hA0) begin $display("FAIL rd_byte1: got %h want a0", d1); errors++; end
        checks++;
        if (re0_idx.size() != 2) begin
            $display("FAIL rd_re_count: got %0d want 2", re0_idx.size()); errors++;
        end else begin
            if (re0_idx[0] !== 5'h1F || re0_idx[1] !== 5'h00) begin
                $display("FAIL rd_re_idx: got %h,%h want 1f,00", re0_idx[0], re0_idx[1]); errors++;
            end
            checks++;
        end
        checks++;
        if (we0_idx.size() != 0) begin $display("FAIL rd_no_we: got %0d want 0", we0_idx.size()); errors++; end
        checks++;
        if (csr_a0 !== 5'h01) begin $display("FAIL rd_ptr_after_nack: got %h want 01", csr_a0); errors++; end
        checks++;
        if (dev_sel0 !== 7'h4a) begin $display("FAIL rd_dev_sel: got %h want 4a", dev_sel0); errors++; end
        checks++;
    endtask

    task automatic test_mask();
        logic a0, a1, b0, b1;
        sel = 1'b1;
        #(4*Q);
        i2c_start();
        i2c_wr_byte(8'h96, a0);
        i2c_wr_byte(8'h05, a1);
        i2c_stop();
        if ({a0, a1} !== 2'b11) begin $display("FAIL mask_acks: got %b want 11", {a0, a1}); errors++; end
        checks++;
        if (dev_sel1 !== 7'h4b) begin $display("FAIL mask_dev_sel: got %h want 4b", dev_sel1); errors++; end
        checks++;
        drv1 = 1'b0;
        we1_idx.delete(); we1_dat.delete(); re1_n = 0;
        i2c_start();
        i2c_wr_byte(8'h74, b0);
        i2c_wr_byte(8'h00, b1);
        i2c_stop();
        if ({b0, b1} !== 2'b00) begin $display("FAIL mask_miss_acks: got %b want 00", {b0, b1}); errors++; end
        checks++;
        if (drv1 !== 1'b0) begin $display("FAIL mask_miss_drive: got %b want 0", drv1); errors++; end
        checks++;
        if (we1_idx.size() != 0 || re1_n != 0) begin
            $display("FAIL mask_miss_strobes: got we %0d re %0d want 0 0", we1_idx.size(), re1_n); errors++;
        end
        checks++;
        if (csr_a1 !== 5'h05) begin $display("FAIL mask_ptr: got %h want 05", csr_a1); errors++; end
        checks++;
    endtask

    task automatic test_depth();
        logic a0, a1, b0, b1, b2;
        sel = 1'b1;
        we1_idx.delete(); we1_dat.delete();
        i2c_start();
        i2c_wr_byte(8'h94, a0);
        i2c_wr_byte(8'h13, a1);
        i2c_stop();
        if ({a0, a1} !== 2'b11) begin $display("FAIL depth_last_acks: got %b want 11", {a0, a1}); errors++; end
        checks++;
        if (csr_a1 !== 5'h13) begin $display("FAIL depth_last_ptr: got %h want 13", csr_a1); errors++; end
        checks++;
        i2c_start();
        i2c_wr_byte(8'h94, b0);
        i2c_wr_byte(8'h14, b1);
        i2c_wr_byte(8'h77, b2);
        i2c_stop();
        if ({b0, b1, b2} !== 3'b100) begin $display("FAIL depth_over_acks: got %b want 100", {b0, b1, b2}); errors++; end
        checks++;
        if (csr_a1 !== 5'h13) begin $display("FAIL depth_over_ptr: got %h want 13", csr_a1); errors++; end
        checks++;
        if (we1_idx.size() != 0) begin $display("FAIL depth_over_we: got %0d want 0", we1_idx.size()); errors++; end
        checks++;
    endtask

    task automatic test_no_autoinc();
        logic a0, a1, a2, a3, a4;
        logic [7:0] exp_dat [3];
        exp_dat[0] = 8'h11; exp_dat[1] = 8'h22; exp_dat[2] = 8'h33;
        sel = 1'b1;
        we1_idx.delete(); we1_dat.delete();
        i2c_start();
        i2c_wr_byte(8'h94, a0);
        i2c_wr_byte(8'h02, a1);
        i2c_wr_byte(8'h11, a2);
        i2c_wr_byte(8'h22, a3);
        i2c_wr_byte(8'h33, a4);
        i2c_stop();
        if ({a0, a1, a2, a3, a4} !== 5'b11111) begin
            $display("FAIL hold_acks: got %b want 11111", {a0, a1, a2, a3, a4}); errors++;
        end
        checks++;
        if (we1_idx.size() != 3) begin
            $display("FAIL hold_count: got %0d want 3", we1_idx.size()); errors++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (we1_idx[i] !== 5'h02 || we1_dat[i] !== exp_dat[i]) begin
                    $display("FAIL hold_we%0d: got idx %h data %h want idx 02 data %h", i, we1_idx[i], we1_dat[i], exp_dat[i]);
                    errors++;
                end
                checks++;
            end
        end
        checks++;
        if (csr_a1 !== 5'h02) begin $display("FAIL hold_ptr: got %h want 02", csr_a1); errors++; end
        checks++;
    endtask

    task automatic test_reset_mid_read();
        logic a0, s;
        sel = 1'b0;
        #(4*Q);
        i2c_start();
        i2c_wr_byte(8'h95, a0);
        i2c_bit(1'b1, s);
        // pointer is 1 so the byte is 0xA1: bit 7 = 1, bit 6 = 0 now on the line
        if (a0 !== 1'b1 || s !== 1'b1) begin $display("FAIL mid_prefix: got ack %b bit7 %b want 1 1", a0, s); errors++; end
        checks++;
        if (sda_out0 !== 1'b0) begin $display("FAIL mid_drive_low: got %b want 0", sda_out0); errors++; end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (sda_out0 !== 1'b1) begin $display("FAIL mid_rst_sda: got %b want 1", sda_out0); errors++; end
        checks++;
        if (dut0.state_q !== ST_IDLE) begin $display("FAIL mid_rst_state: got %0d want IDLE", dut0.state_q); errors++; end
        checks++;
        if (bus_active0 !== 1'b0) begin $display("FAIL mid_rst_bus: got %b want 0", bus_active0); errors++; end
        checks++;
        if (csr_a0 !== 5'd0 || dev_sel0 !== 7'd0) begin
            $display("FAIL mid_rst_regs: got a %h sel %h want 00 00", csr_a0, dev_sel0); errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        i2c_bit(1'b1, s);
        if (s !== 1'b1 || sda_out0 !== 1'b1) begin
            $display("FAIL mid_after_rst: got line %b drive %b want 1 1", s, sda_out0); errors++;
        end
        checks++;
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wrap();
        test_mask();
        test_depth();
        test_no_autoinc();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
